// File: rtl/mux8to1_rr_if.sv
// Bundle of the eight-channel gather bus: per-channel valid/ready/data on the
// input side and one registered valid/ready stream tagged with its source index.
interface mux8to1_rr_if #(
   parameter int WIDTH = 8
);
   logic [7:0]         in_valid;
   logic [8*WIDTH-1:0] in_data;
   logic [7:0]         in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [2:0]         out_sel;
   logic               out_ready;

   // Producer/consumer side of the bus (drives the channels, sinks the stream).
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );

   // Multiplexer side of the bus.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/mux8to1_rr.sv
// Registered 8-to-1 round-robin multiplexer. Eight valid/ready channels are
// merged into one registered output stream; every beat carries the 3-bit index
// of the channel it came from so a downstream 1-to-8 demux can route it back.
// The priority pointer moves to one past the last granted channel, so a
// granted channel becomes lowest priority for the next grant.
module mux8to1_rr #(
   parameter int WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   mux8to1_rr_if.slave bus
);
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [2:0]       out_sel_q,   out_sel_d;
   logic [2:0]       prio_q,      prio_d;

   logic             load;
   logic             any_vld;
   logic [2:0]       gnt;
   logic [2:0]       idx;

   // Output register is free when empty or being drained this very cycle.
   assign load = !out_valid_q || bus.out_ready;

   // Rotating-priority search: scan from prio upward, first valid channel wins.
   // Scanning the offsets downward lets the smallest offset overwrite last.
   always_comb begin
      any_vld = 1'b0;
      gnt     = prio_q;
      idx     = '0;
      for (int k = 7; k >= 0; k--) begin
         idx = prio_q + 3'(k);
         if (bus.in_valid[idx]) begin
            gnt     = idx;
            any_vld = 1'b1;
         end
      end
   end

   // Grant strobe back to the winning channel; held off entirely during reset.
   always_comb begin
      bus.in_ready = '0;
      if (!rst && load && any_vld) begin
         bus.in_ready = 8'(1) << gnt;
      end
   end

   // Next-state for the output register and priority pointer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      prio_d      = prio_q;
      if (load) begin
         if (any_vld) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data[gnt*WIDTH +: WIDTH];
            out_sel_d   = gnt;
            prio_d      = gnt + 3'd1;
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   // State registers; reset discards any held beat immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         prio_q      <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         prio_q      <= prio_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_mux8to1_rr.sv
// Directed bench for mux8to1_rr: stimulus pushes hand-computed beats
// {sel,data} into a queue; a monitor pops one per output handshake, compares,
// and routes the beat through a small 1-to-8 demux model on out_sel.
module tb_mux8to1_rr;
   logic clk = 1'b0;
   logic rst;

   mux8to1_rr_if #(.WIDTH(8)) bus ();

   mux8to1_rr #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   logic [10:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [10:0] beat(input int ch);
      logic [2:0] s;
      logic [7:0] d;
      s = 3'(ch);
      d = 8'hA0 + 8'(ch);
      return {s, d};
   endfunction

   // Monitor: one pop per handshake, plus the demux return-path check.
   initial begin
      logic [10:0] e;
      logic [7:0]  dmx_valid;
      int          route_ch;
      forever begin
         @(negedge clk);
         if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", {29'd0, bus.out_sel}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("beat_sel",  {29'd0, bus.out_sel}, {29'd0, e[10:8]});
               chk("beat_data", {24'd0, bus.out_data}, {24'd0, e[7:0]});
               dmx_valid = 8'(1) << bus.out_sel;
               route_ch  = -1;
               for (int j = 0; j < 8; j++) if (dmx_valid[j]) route_ch = j;
               chk("demux_route", route_ch, {24'd0, e[7:0] - 8'hA0});
            end
         end
      end
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      int b;
      rst = 1'b1;
      bus.in_valid  = 8'hFF;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) bus.in_data[i*8 +: 8] = 8'hA0 + 8'(i);

      // Reset with every channel offering data
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready",  {24'd0, bus.in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_data",  {24'd0, bus.out_data}, 32'd0);
      chk("rst_out_sel",   {29'd0, bus.out_sel}, 32'd0);

      // All eight valid, full throughput: 0..7 then wrap to 0
      for (int i = 0; i < 8; i++) exp_q.push_back(beat(i));
      exp_q.push_back(beat(0));
      rst = 1'b0;
      #1;
      for (int k = 0; k < 9; k++) begin
         chk("rr_in_ready", {24'd0, bus.in_ready}, 32'(8'(1) << (k % 8)));
         @(posedge clk); #1;
         chk("rr_no_bubble", {31'd0, bus.out_valid}, 32'd1);
      end
      bus.in_valid = 8'h00;

      // Idle gap: output empties, sel and prio hold (prio = 1)
      @(posedge clk); #1;
      chk("idle_valid",     {31'd0, bus.out_valid}, 32'd0);
      chk("idle_sel_hold",  {29'd0, bus.out_sel}, 32'd0);
      chk("idle_data_hold", {24'd0, bus.out_data}, 32'hA0);
      bus.in_valid = 8'h03;
      exp_q.push_back(beat(1));
      exp_q.push_back(beat(0));
      #1;
      chk("idle_prio_kept", {24'd0, bus.in_ready}, 32'h02);
      @(posedge clk); #1;
      chk("lat1_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("lat1_sel",   {29'd0, bus.out_sel}, 32'd1);
      bus.in_valid = 8'h01;
      @(posedge clk); #1;
      bus.in_valid = 8'h00;

      // Single channels: ch5 (prio->6), ch2 (prio->3), ch7 (prio wraps to 0)
      bus.in_valid = 8'h20; exp_q.push_back(beat(5));
      @(posedge clk); #1;
      bus.in_valid = 8'h04; exp_q.push_back(beat(2));
      @(posedge clk); #1;
      bus.in_valid = 8'h80; exp_q.push_back(beat(7));
      @(posedge clk); #1;
      bus.in_valid = 8'h41;
      exp_q.push_back(beat(0));
      exp_q.push_back(beat(6));
      #1;
      chk("prio_wrap", {24'd0, bus.in_ready}, 32'h01);
      @(posedge clk); #1;
      bus.in_valid = 8'h40;
      @(posedge clk); #1;
      bus.in_valid = 8'h00;

      // Backpressure on a ch3 beat (prio -> 4), others waiting
      bus.in_valid = 8'h08; exp_q.push_back(beat(3));
      @(posedge clk); #1;
      bus.in_valid  = 8'h52;
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("stall_in_ready", {24'd0, bus.in_ready}, 32'd0);
         chk("stall_valid",    {31'd0, bus.out_valid}, 32'd1);
         chk("stall_sel",      {29'd0, bus.out_sel}, 32'd3);
         chk("stall_data",     {24'd0, bus.out_data}, 32'hA3);
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      exp_q.push_back(beat(4));
      exp_q.push_back(beat(6));
      exp_q.push_back(beat(1));
      #1;
      chk("bp_resume_grant", {24'd0, bus.in_ready}, 32'h10);
      @(posedge clk); #1;
      bus.in_valid = 8'h42;
      @(posedge clk); #1;
      bus.in_valid = 8'h02;
      @(posedge clk); #1;
      bus.in_valid = 8'h00;

      // Async reset while a ch5 beat is stalled
      bus.in_valid = 8'h20;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 8'hFF;
      #1;
      chk("prerst_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("prerst_sel",   {29'd0, bus.out_sel}, 32'd5);
      rst = 1'b1;
      #1;
      chk("async_valid",    {31'd0, bus.out_valid}, 32'd0);
      chk("async_data",     {24'd0, bus.out_data}, 32'd0);
      chk("async_sel",      {29'd0, bus.out_sel}, 32'd0);
      chk("async_in_ready", {24'd0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
      chk("rst_hold_in_ready", {24'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 8'h84;
      exp_q.push_back(beat(2));
      exp_q.push_back(beat(7));
      #1;
      chk("post_rst_grant", {24'd0, bus.in_ready}, 32'h04);
      @(posedge clk); #1;
      bus.in_valid = 8'h80;
      @(posedge clk); #1;
      bus.in_valid = 8'h00;

      // Drain the scoreboard with a bounded wait
      b = 0;
      while (exp_q.size() != 0 && b < 20) begin
         @(posedge clk);
         b++;
      end
      @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
